// File: rtl/costas_run_monitor.sv
// Run controller and result monitor for N_CH Costas demodulator channels.
// Optional per-channel inter-byte stall detection is enabled by defining STALL_DETECT_EN.
module costas_run_monitor #(
    parameter int unsigned N_CH         = 4,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned BCNT_W       = 16,
    parameter int unsigned STALL_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [CNT_W-1:0]       maxCycles,
    input  logic [N_CH-1:0]        pushByte,
    input  logic [8*N_CH-1:0]      Byte,
    input  logic [N_CH-1:0]        Sync,
    input  logic [N_CH-1:0]        lastByte,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout,
    output logic [N_CH-1:0]        chDone,
    output logic [BCNT_W*N_CH-1:0] byteCnt,
    output logic [16*N_CH-1:0]     chkSum,
    output logic [CNT_W-1:0]       cycleCnt,
    output logic [N_CH-1:0]        stall
);

    typedef enum logic [1:0] {StIdle, StRun, StFinish} run_state_e;
    typedef enum logic [1:0] {ChWait, ChRx, ChEnd} ch_state_e;

    localparam logic [CNT_W-1:0]  CntOne  = 1;
    localparam logic [BCNT_W-1:0] BcntOne = 1;

    run_state_e       state;
    logic [CNT_W-1:0] budget;
    logic             running;
    logic             restart;
    logic [N_CH-1:0]  fin;
    logic             all_done_next;
    logic             limit_hit;

    assign running       = (state == StRun);
    assign restart       = start && (state != StRun);
    // A channel finishing on the limit cycle counts as finished, so done wins over timeout.
    assign all_done_next = &(chDone | fin);
    assign limit_hit     = (budget != '0) && (cycleCnt == budget - CntOne);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= StIdle;
            budget   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            timeout  <= 1'b0;
            cycleCnt <= '0;
        end else begin
            case (state)
                StIdle, StFinish: begin
                    if (start) begin
                        state    <= StRun;
                        budget   <= maxCycles;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        timeout  <= 1'b0;
                        cycleCnt <= '0;
                    end
                end
                StRun: begin
                    if (cycleCnt != '1) begin
                        cycleCnt <= cycleCnt + CntOne;
                    end
                    if (&chDone) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= StFinish;
                    end else if (limit_hit && !all_done_next) begin
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        state   <= StFinish;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        ch_state_e         st;
        logic [BCNT_W-1:0] cnt;
        logic [15:0]       sum;
        logic              ch_done_q;
        logic [7:0]        b;
        logic              accept;
        logic              last;
        logic              stall_hit;

        assign b      = Byte[8*i +: 8];
        // Outside RX a byte is only taken together with Sync.
        assign accept = running && pushByte[i] && ((st == ChRx) || ((st == ChWait) && Sync[i]));
        assign last   = accept && lastByte[i];
        assign fin[i] = last || stall_hit;

        always_ff @(posedge clk) begin
            if (reset || restart) begin
                st        <= ChWait;
                cnt       <= '0;
                sum       <= '0;
                ch_done_q <= 1'b0;
            end else if (running) begin
                if (accept) begin
                    if (cnt != '1) begin
                        cnt <= cnt + BcntOne;
                    end
                    sum <= sum + {8'h00, b};
                end
                case (st)
                    ChWait:  if (Sync[i]) st <= last ? ChEnd : ChRx;
                    ChRx:    if (fin[i]) st <= ChEnd;
                    default: st <= ChEnd;
                endcase
                if (fin[i]) begin
                    ch_done_q <= 1'b1;
                end
            end
        end

`ifdef STALL_DETECT_EN
        localparam int unsigned  GapW    = $clog2(STALL_CYCLES + 1);
        localparam logic [GapW-1:0] GapOne  = 1;
        localparam logic [GapW-1:0] GapLast = GapW'(STALL_CYCLES - 1);

        logic [GapW-1:0] gap;
        logic            stall_q;

        // The idle cycle that brings the gap to STALL_CYCLES closes the channel.
        assign stall_hit = running && (st == ChRx) && !pushByte[i] && (gap == GapLast);

        always_ff @(posedge clk) begin
            if (reset || restart) begin
                gap     <= '0;
                stall_q <= 1'b0;
            end else if (running) begin
                if ((st == ChWait) && Sync[i]) begin
                    gap <= '0;
                end else if (st == ChRx) begin
                    gap <= pushByte[i] ? '0 : gap + GapOne;
                end
                if (stall_hit) begin
                    stall_q <= 1'b1;
                end
            end
        end

        assign stall[i] = stall_q;
`else
        assign stall_hit = 1'b0;
        assign stall[i]  = 1'b0;
`endif

        assign chDone[i]                   = ch_done_q;
        assign byteCnt[BCNT_W*i +: BCNT_W] = cnt;
        assign chkSum[16*i +: 16]          = sum;
    end

endmodule
